// File: rtl/ycbcr_thresh_pkg.sv
// ---------------------------------------------------------------------------
// ycbcr_thresh_pkg
// Shared definitions for the YCbCr threshold controller:
//   - configuration address map for the four chroma thresholds
//   - power-on default thresholds (skin-tone style Cb/Cr window)
//   - controller FSM state encoding
//   - threshold set struct and its validity rule
// ---------------------------------------------------------------------------
package ycbcr_thresh_pkg;

  localparam logic [1:0] ADDR_CB_LO = 2'd0;
  localparam logic [1:0] ADDR_CB_HI = 2'd1;
  localparam logic [1:0] ADDR_CR_LO = 2'd2;
  localparam logic [1:0] ADDR_CR_HI = 2'd3;

  localparam logic [7:0] DEF_CB_LO = 8'd0;
  localparam logic [7:0] DEF_CB_HI = 8'd115;
  localparam logic [7:0] DEF_CR_LO = 8'd145;
  localparam logic [7:0] DEF_CR_HI = 8'd170;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] cb_lo;
    logic [7:0] cb_hi;
    logic [7:0] cr_lo;
    logic [7:0] cr_hi;
  } thr_t;

  localparam thr_t THR_DEFAULT = '{
    cb_lo: DEF_CB_LO,
    cb_hi: DEF_CB_HI,
    cr_lo: DEF_CR_LO,
    cr_hi: DEF_CR_HI
  };

  // A threshold set is usable only if both windows are non-empty.
  function automatic logic thr_valid(input thr_t t);
    return (t.cb_lo < t.cb_hi) && (t.cr_lo < t.cr_hi);
  endfunction

endpackage

// File: rtl/ycbcr_thresh_ctrl_vsync_edge.sv
// ---------------------------------------------------------------------------
// vsync_edge
// Registers the incoming frame sync and flags its rising edge.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   v_sync_i - frame sync from the video pipeline
//   rise_o   - combinational: v_sync_i high while last-cycle sample was low
// ---------------------------------------------------------------------------
module vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic v_sync_i,
  output logic rise_o
);

  logic v_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_sync_q <= 1'b0;
    end else begin
      v_sync_q <= v_sync_i;
    end
  end

  assign rise_o = v_sync_i & ~v_sync_q;

endmodule

// File: rtl/ycbcr_thresh_ctrl.sv
// ---------------------------------------------------------------------------
// ycbcr_thresh_ctrl
// Frame-synchronous threshold controller for a YCbCr binarizer, plus a
// per-frame foreground pixel counter.
//
// Threshold writes land in a shadow register set; on the next v_sync rising
// edge the shadow is validated and, if both windows are non-empty, copied to
// the active thresholds in a single one-cycle COMMIT state.
//
// Ports:
//   clk, rst_n              - clock and synchronous active-low reset
//   cfg_valid/cfg_ready     - threshold write handshake
//   cfg_addr, cfg_data      - threshold select (cb_lo/cb_hi/cr_lo/cr_hi), value
//   v_sync_in               - frame sync, rising edge = frame start
//   de_in, mask_in          - pixel enable and binarizer result
//   thr_cb_lo..thr_cr_hi    - active thresholds
//   cfg_pending             - a commit is awaited (ARMED or COMMIT)
//   cfg_err                 - last commit attempt rejected (sticky)
//   fg_count, frame_cnt     - last frame's foreground count, completed frames
//   frame_done              - one-cycle pulse when fg_count/frame_cnt update
// ---------------------------------------------------------------------------
module ycbcr_thresh_ctrl
  import ycbcr_thresh_pkg::*;
#(
  parameter int unsigned CNT_W = 22,
  parameter int unsigned FRM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             v_sync_in,
  input  logic             de_in,
  input  logic             mask_in,
  output logic [7:0]       thr_cb_lo,
  output logic [7:0]       thr_cb_hi,
  output logic [7:0]       thr_cr_lo,
  output logic [7:0]       thr_cr_hi,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [CNT_W-1:0] fg_count,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

  state_e            state_q, state_d;
  thr_t              shadow_q, shadow_d;
  thr_t              active_q, active_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  fg_q, fg_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic              done_q, done_d;

  logic              vs_rise;
  logic              wr_en;
  logic              pix_fg;

  vsync_edge u_vsync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .v_sync_i (v_sync_in),
    .rise_o   (vs_rise)
  );

  // Ready depends only on state so the write strobe has no combinational loop.
  assign cfg_ready = (state_q != COMMIT);
  assign wr_en     = cfg_valid & cfg_ready;
  assign pix_fg    = de_in & mask_in;

  // -------------------------------------------------------------------------
  // Controller FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cfg_pending = 1'b0;
    case (state_q)
      IDLE: begin
        // A write coinciding with the sync edge must make this frame's
        // commit, so it skips ARMED and commits straight away.
        if (wr_en) begin
          state_d = vs_rise ? COMMIT : ARMED;
        end
      end
      ARMED: begin
        cfg_pending = 1'b1;
        if (vs_rise) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cfg_pending = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Shadow / active thresholds and commit error flag
  // -------------------------------------------------------------------------
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;

    if (wr_en) begin
      err_d = 1'b0;
      case (cfg_addr)
        ADDR_CB_LO: shadow_d.cb_lo = cfg_data;
        ADDR_CB_HI: shadow_d.cb_hi = cfg_data;
        ADDR_CR_LO: shadow_d.cr_lo = cfg_data;
        ADDR_CR_HI: shadow_d.cr_hi = cfg_data;
        default:    shadow_d       = shadow_q;
      endcase
    end

    // No write can be accepted in COMMIT, so this never races the clear above.
    // A rejected set stays in the shadow for the host to repair.
    if (state_q == COMMIT) begin
      if (thr_valid(shadow_q)) begin
        active_d = shadow_q;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Foreground pixel accumulator and frame statistics
  // -------------------------------------------------------------------------
  always_comb begin
    acc_d   = acc_q;
    fg_d    = fg_q;
    frame_d = frame_q;
    done_d  = 1'b0;

    if (vs_rise) begin
      // The edge-cycle pixel belongs to the new frame.
      fg_d    = acc_q;
      acc_d   = pix_fg ? ACC_ONE : '0;
      frame_d = frame_q + FRM_ONE;
      done_d  = 1'b1;
    end else if (pix_fg && (acc_q != '1)) begin
      acc_d   = acc_q + ACC_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= THR_DEFAULT;
      active_q <= THR_DEFAULT;
      err_q    <= 1'b0;
      acc_q    <= '0;
      fg_q     <= '0;
      frame_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      fg_q     <= fg_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
    end
  end

  assign thr_cb_lo  = active_q.cb_lo;
  assign thr_cb_hi  = active_q.cb_hi;
  assign thr_cr_lo  = active_q.cr_lo;
  assign thr_cr_hi  = active_q.cr_hi;
  assign cfg_err    = err_q;
  assign fg_count   = fg_q;
  assign frame_cnt  = frame_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ycbcr_thresh_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ycbcr_thresh_ctrl
// Self-checking bench for ycbcr_thresh_ctrl. A second instance with narrow
// counters (CNT_W=3, FRM_W=2) shares all inputs to expose saturation and
// frame-counter wrap. Frame statistics are scoreboarded: each driven v_sync
// rising edge pushes the expected fg_count/frame_cnt, popped on frame_done.
// ---------------------------------------------------------------------------
module tb_ycbcr_thresh_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_data = 8'd0;
  logic        v_sync_in = 1'b0;
  logic        de_in = 1'b0;
  logic        mask_in = 1'b0;

  logic        cfg_ready, cfg_pending, cfg_err, frame_done;
  logic [7:0]  thr_cb_lo, thr_cb_hi, thr_cr_lo, thr_cr_hi;
  logic [21:0] fg_count;
  logic [15:0] frame_cnt;

  logic        s_cfg_ready, s_cfg_pending, s_cfg_err, s_frame_done;
  logic [31:0] s_thr;
  logic [2:0]  s_fg_count;
  logic [1:0]  s_frame_cnt;

  always #5 clk = ~clk;

  ycbcr_thresh_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .v_sync_in(v_sync_in),
    .de_in(de_in), .mask_in(mask_in), .thr_cb_lo(thr_cb_lo),
    .thr_cb_hi(thr_cb_hi), .thr_cr_lo(thr_cr_lo), .thr_cr_hi(thr_cr_hi),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .fg_count(fg_count),
    .frame_cnt(frame_cnt), .frame_done(frame_done)
  );

  ycbcr_thresh_ctrl #(.CNT_W(3), .FRM_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .v_sync_in(v_sync_in),
    .de_in(de_in), .mask_in(mask_in), .thr_cb_lo(s_thr[31:24]),
    .thr_cb_hi(s_thr[23:16]), .thr_cr_lo(s_thr[15:8]), .thr_cr_hi(s_thr[7:0]),
    .cfg_pending(s_cfg_pending), .cfg_err(s_cfg_err), .fg_count(s_fg_count),
    .frame_cnt(s_frame_cnt), .frame_done(s_frame_done)
  );

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  typedef struct {
    logic [21:0] fg;
    logic [15:0] frm;
  } frame_exp_t;

  frame_exp_t  exp_q[$];
  frame_exp_t  mon_e;
  int unsigned m_acc = 0;
  int unsigned m_frames = 0;
  logic        m_vs_prev = 1'b0;

  // Scoreboard consumer: every frame_done must match a driven sync edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done_unexpected got pulse fg_count=%0d frame_cnt=%0d exp no pulse", fg_count, frame_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (fg_count !== mon_e.fg || frame_cnt !== mon_e.frm) begin
          errors++;
          $display("FAIL frame_stats got fg=%0d frm=%0d exp fg=%0d frm=%0d", fg_count, frame_cnt, mon_e.fg, mon_e.frm);
        end
      end
    end
  end

  // One clock cycle of stimulus; updates the frame model and pushes the
  // expected statistics whenever a sync rising edge is driven.
  task automatic cyc(input logic vs, input logic de, input logic mk,
                     input logic wv, input logic [1:0] a, input logic [7:0] d);
    v_sync_in = vs; de_in = de; mask_in = mk;
    cfg_valid = wv; cfg_addr = a; cfg_data = d;
    if (!rst_n) begin
      m_acc = 0; m_frames = 0; m_vs_prev = 1'b0;
    end else begin
      if (vs && !m_vs_prev) begin
        m_frames++;
        exp_q.push_back('{fg: m_acc[21:0], frm: m_frames[15:0]});
        m_acc = (de && mk) ? 1 : 0;
      end else if (de && mk) begin
        m_acc++;
      end
      m_vs_prev = vs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic vs);
    cyc(vs, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) idle(1'b0);
    rst_n = 1'b1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drained got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (thr_cb_lo !== 8'd0)   begin errors++; $display("FAIL rst_cb_lo got %0d exp 0", thr_cb_lo); end
    checks++; if (thr_cb_hi !== 8'd115) begin errors++; $display("FAIL rst_cb_hi got %0d exp 115", thr_cb_hi); end
    checks++; if (thr_cr_lo !== 8'd145) begin errors++; $display("FAIL rst_cr_lo got %0d exp 145", thr_cr_lo); end
    checks++; if (thr_cr_hi !== 8'd170) begin errors++; $display("FAIL rst_cr_hi got %0d exp 170", thr_cr_hi); end
    checks++; if (cfg_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready got %b exp 1", cfg_ready); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", cfg_pending); end
    checks++; if (cfg_err !== 1'b0)     begin errors++; $display("FAIL rst_err got %b exp 0", cfg_err); end
    checks++; if (fg_count !== 22'd0)   begin errors++; $display("FAIL rst_fg got %0d exp 0", fg_count); end
    checks++; if (frame_cnt !== 16'd0)  begin errors++; $display("FAIL rst_frm got %0d exp 0", frame_cnt); end
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
    idle(1'b0);
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL idle_pending got %b exp 0", cfg_pending); end
  endtask

  task automatic test_commit();
    wr(2'd1, 8'd120);
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL armed_pending got %b exp 1", cfg_pending); end
    checks++; if (cfg_ready !== 1'b1)   begin errors++; $display("FAIL armed_ready got %b exp 1", cfg_ready); end
    idle(1'b1);                                   // edge cycle N
    checks++; if (cfg_ready !== 1'b0)   begin errors++; $display("FAIL commit_ready got %b exp 0", cfg_ready); end
    checks++; if (s_cfg_ready !== 1'b0) begin errors++; $display("FAIL sat_commit_ready got %b exp 0", s_cfg_ready); end
    checks++; if (thr_cb_hi !== 8'd115) begin errors++; $display("FAIL commit_early got %0d exp 115", thr_cb_hi); end
    idle(1'b1);                                   // N+2 view
    checks++; if (thr_cb_hi !== 8'd120) begin errors++; $display("FAIL commit_cb_hi got %0d exp 120", thr_cb_hi); end
    checks++; if (s_thr !== {8'd0, 8'd120, 8'd145, 8'd170}) begin errors++; $display("FAIL sat_thr got %h exp 007891aa", s_thr); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL commit_pending got %b exp 0", cfg_pending); end
    checks++; if (s_cfg_pending !== 1'b0) begin errors++; $display("FAIL sat_pending got %b exp 0", s_cfg_pending); end
    checks++; if (cfg_err !== 1'b0)     begin errors++; $display("FAIL commit_err got %b exp 0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1)   begin errors++; $display("FAIL post_commit_ready got %b exp 1", cfg_ready); end
    idle(1'b0);
  endtask

  task automatic test_reject();
    wr(2'd0, 8'd200);
    idle(1'b1);
    idle(1'b1);
    checks++; if (cfg_err !== 1'b1)     begin errors++; $display("FAIL reject_err got %b exp 1", cfg_err); end
    checks++; if (s_cfg_err !== 1'b1)   begin errors++; $display("FAIL sat_reject_err got %b exp 1", s_cfg_err); end
    checks++; if (thr_cb_lo !== 8'd0)   begin errors++; $display("FAIL reject_cb_lo got %0d exp 0", thr_cb_lo); end
    checks++; if (thr_cb_hi !== 8'd120) begin errors++; $display("FAIL reject_cb_hi got %0d exp 120", thr_cb_hi); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reject_pending got %b exp 0", cfg_pending); end
    idle(1'b0);
    checks++; if (cfg_err !== 1'b1)     begin errors++; $display("FAIL err_sticky got %b exp 1", cfg_err); end
    wr(2'd3, 8'd171);
    checks++; if (cfg_err !== 1'b0)     begin errors++; $display("FAIL err_clear_wr got %b exp 0", cfg_err); end
    idle(1'b1);
    idle(1'b1);
    // cb_lo=200 was retained in the shadow, so this commit fails again
    checks++; if (cfg_err !== 1'b1)     begin errors++; $display("FAIL retain_err got %b exp 1", cfg_err); end
    checks++; if (thr_cr_hi !== 8'd170) begin errors++; $display("FAIL retain_cr_hi got %0d exp 170", thr_cr_hi); end
    idle(1'b0);
    wr(2'd0, 8'd10);
    checks++; if (cfg_err !== 1'b0)     begin errors++; $display("FAIL fix_err got %b exp 0", cfg_err); end
    idle(1'b1);
    idle(1'b1);
    checks++; if (thr_cb_lo !== 8'd10)  begin errors++; $display("FAIL fix_cb_lo got %0d exp 10", thr_cb_lo); end
    checks++; if (thr_cr_hi !== 8'd171) begin errors++; $display("FAIL fix_cr_hi got %0d exp 171", thr_cr_hi); end
    checks++; if (cfg_err !== 1'b0)     begin errors++; $display("FAIL fix_err_commit got %b exp 0", cfg_err); end
    idle(1'b0);
  endtask

  task automatic test_same_cycle();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd180);   // write + edge from IDLE
    checks++; if (cfg_ready !== 1'b0)   begin errors++; $display("FAIL same_idle_ready got %b exp 0", cfg_ready); end
    idle(1'b1);
    checks++; if (thr_cr_hi !== 8'd180) begin errors++; $display("FAIL same_idle_cr_hi got %0d exp 180", thr_cr_hi); end
    idle(1'b0);
    wr(2'd2, 8'd150);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd190);   // write + edge from ARMED
    idle(1'b1);
    checks++; if (thr_cr_lo !== 8'd150) begin errors++; $display("FAIL same_armed_cr_lo got %0d exp 150", thr_cr_lo); end
    checks++; if (thr_cr_hi !== 8'd190) begin errors++; $display("FAIL same_armed_cr_hi got %0d exp 190", thr_cr_hi); end
    idle(1'b0);
  endtask

  task automatic test_frame_count();
    int p0;
    do_reset(2);
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b1, ((i % 27) == 5), 1'b0, 2'd0, 8'd0);
    p0 = done_pulses;
    idle(1'b1);
    checks++; if (frame_done !== 1'b1)  begin errors++; $display("FAIL f1_done got %b exp 1", frame_done); end
    checks++; if (s_frame_done !== 1'b1) begin errors++; $display("FAIL sat_f1_done got %b exp 1", s_frame_done); end
    checks++; if (fg_count !== 22'd37)  begin errors++; $display("FAIL f1_fg got %0d exp 37", fg_count); end
    checks++; if (frame_cnt !== 16'd1)  begin errors++; $display("FAIL f1_frm got %0d exp 1", frame_cnt); end
    checks++; if (s_fg_count !== 3'd7)  begin errors++; $display("FAIL sat_fg got %0d exp 7", s_fg_count); end
    idle(1'b0);
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL f1_done_width got %b exp 0", frame_done); end
    checks++; if (done_pulses !== p0 + 1) begin errors++; $display("FAIL f1_pulses got %0d exp %0d", done_pulses, p0 + 1); end
    for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    idle(1'b1);
    checks++; if (fg_count !== 22'd0)   begin errors++; $display("FAIL f2_fg got %0d exp 0", fg_count); end
    checks++; if (frame_cnt !== 16'd2)  begin errors++; $display("FAIL f2_frm got %0d exp 2", frame_cnt); end
    idle(1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);     // edge-cycle pixel starts next frame
    checks++; if (fg_count !== 22'd5)   begin errors++; $display("FAIL f3_fg got %0d exp 5", fg_count); end
    idle(1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(1'b1);
    checks++; if (fg_count !== 22'd4)   begin errors++; $display("FAIL f4_fg got %0d exp 4", fg_count); end
    checks++; if (s_frame_cnt !== 2'd0) begin errors++; $display("FAIL sat_wrap got %0d exp 0", s_frame_cnt); end
    idle(1'b0);
    idle(1'b1);
    checks++; if (frame_cnt !== 16'd5)  begin errors++; $display("FAIL f5_frm got %0d exp 5", frame_cnt); end
    checks++; if (s_frame_cnt !== 2'd1) begin errors++; $display("FAIL sat_f5_frm got %0d exp 1", s_frame_cnt); end
    idle(1'b0);
  endtask

  task automatic test_reset_mid_op();
    wr(2'd2, 8'd100);
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL rma_pending got %b exp 1", cfg_pending); end
    do_reset(1);
    checks++; if (thr_cr_lo !== 8'd145) begin errors++; $display("FAIL rma_cr_lo got %0d exp 145", thr_cr_lo); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rma_idle got %b exp 0", cfg_pending); end
    idle(1'b1);
    checks++; if (cfg_ready !== 1'b1)   begin errors++; $display("FAIL rma_no_commit got %b exp 1", cfg_ready); end
    idle(1'b1);
    checks++; if (thr_cr_lo !== 8'd145) begin errors++; $display("FAIL rma_after_edge got %0d exp 145", thr_cr_lo); end
    idle(1'b0);
    wr(2'd2, 8'd100);
    idle(1'b1);
    checks++; if (cfg_ready !== 1'b0)   begin errors++; $display("FAIL rmc_in_commit got %b exp 0", cfg_ready); end
    do_reset(1);                                  // reset lands on the COMMIT cycle
    checks++; if (thr_cr_lo !== 8'd145) begin errors++; $display("FAIL rmc_cr_lo got %0d exp 145", thr_cr_lo); end
    checks++; if (cfg_err !== 1'b0)     begin errors++; $display("FAIL rmc_err got %b exp 0", cfg_err); end
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    checks++; if (thr_cr_lo !== 8'd145) begin errors++; $display("FAIL rmc_after_edge got %0d exp 145", thr_cr_lo); end
    idle(1'b0);
    idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_commit();
    test_reject();
    test_same_cycle();
    test_frame_count();
    test_reset_mid_op();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_scoreboard got %0d pending exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
